// File: rtl/runup_pkg.sv
// Shared types and defaults for the run-up test controller.
// Holds the FSM state encoding, the default geometry and the readout beat-index width.
package runup_pkg;

    localparam int DEF_NUM_BINS = 32;
    localparam int DEF_CNT_W    = 64;
    localparam int DEF_BEAT_W   = $clog2(DEF_NUM_BINS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_READOUT,
        ST_DONE
    } state_t;

    // Beat index must cover total + NUM_BINS bins, i.e. 0..NUM_BINS.
    function automatic int beat_width(input int num_bins);
        return $clog2(num_bins + 1);
    endfunction

endpackage

// File: rtl/runup_wdog.sv
// Stall counter for the run-up controller: counts consecutive ticks and flags
// expiry combinationally on the LIMIT-th consecutive tick.
module runup_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (tick && (r_count != W'(LIMIT))) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = tick && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/runup_test_ctrl.sv
// Run-up test controller: clears the datapath, feeds num_words sample words, then streams
// total + histogram bins. Optional RUN-stall watchdog enabled by defining RUNUP_CTRL_WATCHDOG_EN.
module runup_test_ctrl
    import runup_pkg::*;
#(
    parameter int NUM_BINS  = DEF_NUM_BINS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WD_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_words,
    input  logic                        src_valid,
    output logic                        src_ready,
    output logic                        dp_clr,
    output logic                        dp_adv,
    input  logic [CNT_W-1:0]            dp_total,
    output logic [$clog2(NUM_BINS)-1:0] bin_sel,
    input  logic [CNT_W-1:0]            bin_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [CNT_W-1:0]            res_data,
    output logic                        res_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int SEL_W  = $clog2(NUM_BINS);
    localparam int BEAT_W = beat_width(NUM_BINS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BINS);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [BEAT_W-1:0]  r_beat;
    logic               w_accept;
    logic               w_beat_xfer;
    logic               w_expired;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_beat_xfer = res_valid && res_ready;

`ifdef RUNUP_CTRL_WATCHDOG_EN
    logic r_err;
    logic w_wd_tick;

    // Only a stalled source counts; any valid word or leaving RUN restarts the count.
    assign w_wd_tick = (r_state == ST_RUN) && src_ready && !src_valid;

    runup_wdog #(
        .LIMIT   (WD_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_wd_tick),
        .tick    (w_wd_tick),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err <= 1'b0;
        end else if (w_expired) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_expired = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != ST_IDLE);
        dp_clr       = 1'b0;
        src_ready    = 1'b0;
        dp_adv       = 1'b0;
        res_valid    = 1'b0;
        res_last     = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                dp_clr       = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                src_ready = (r_remaining != '0);
                dp_adv    = src_valid && src_ready;
                if (w_expired) begin
                    w_state_next = ST_DONE;
                end else if ((r_remaining == '0) || (dp_adv && (r_remaining == CNT_W'(1)))) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_state_next = ST_READOUT;
            end
            ST_READOUT: begin
                res_valid = 1'b1;
                res_last  = (r_beat == LAST_BEAT);
                if (w_beat_xfer && res_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // src_ready already guarantees remaining > 0, so the decrement cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (w_accept) begin
            r_remaining <= num_words;
        end else if (dp_adv) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_beat <= '0;
        end else if (w_beat_xfer) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
        end
    end

    // Beat 0 carries the total; beat k presents bin k-1.
    assign bin_sel  = (r_beat == '0) ? '0 : SEL_W'(r_beat - BEAT_W'(1));
    assign res_data = (r_state != ST_READOUT) ? '0 :
                      (r_beat == '0)          ? dp_total : bin_data;

endmodule

// File: doc/runup_test_ctrl.md
RUNUP_TEST_CTRL -- requirements
Module: runup_test_ctrl

Interface
REQ-001 SHALL have parameter NUM_BINS, default 32, histogram bins read out per test.
REQ-002 SHALL have parameter CNT_W, default 64, width of word counter, total and bin data.
REQ-003 SHALL have parameter WD_CYCLES, default 1024, watchdog stall limit in cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a test; sampled only in IDLE.
REQ-007 SHALL have port num_words  input  CNT_W  test length in 4-sample words; captured on accepted start.
REQ-008 SHALL have ports src_valid (input, 1) and src_ready (output, 1)  handshake with the 4x32-bit sample source.
REQ-009 SHALL have port dp_clr  output  1  clears the run-up datapath counters.
REQ-010 SHALL have port dp_adv  output  1  datapath consumes the current 4-sample word.
REQ-011 SHALL have ports dp_total (input, CNT_W), bin_sel (output, $clog2(NUM_BINS)) and bin_data (input, CNT_W); bin_data is combinational from bin_sel.
REQ-012 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, CNT_W) and res_last (output, 1)  result stream.
REQ-013 SHALL have ports busy, done and err  outputs, 1 bit each  status.

Function
REQ-014 SHALL implement states IDLE, CLEAR, RUN, SETTLE, READOUT, DONE.
REQ-015 IDLE plus start=1 SHALL capture num_words, clear err and go to CLEAR; start in any other state SHALL be ignored.
REQ-016 CLEAR SHALL last exactly 1 cycle with dp_clr=1, then go to RUN.
REQ-017 In RUN, src_ready SHALL be 1 while remaining words > 0, and dp_adv SHALL equal src_valid & src_ready.
REQ-018 Each dp_adv cycle SHALL decrement remaining by 1; when the final word is accepted, the next state SHALL be SETTLE.
REQ-019 num_words=0 SHALL pass CLEAR -> RUN -> SETTLE with no dp_adv and read out all zeros.
REQ-020 SETTLE SHALL last 1 cycle (datapath output register latency), then go to READOUT.
REQ-021 READOUT SHALL emit NUM_BINS+1 beats: beat 0 = dp_total; beat k = bin_data with bin_sel=k-1; res_last=1 only on the final beat.
REQ-022 A beat SHALL advance only on res_valid & res_ready; res_data and res_last SHALL stay stable while res_ready=0.
REQ-023 After the last beat transfers, the FSM SHALL go to DONE, assert done for exactly 1 cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; dp_clr, dp_adv and res_valid SHALL be 0 outside CLEAR, RUN and READOUT respectively.
REQ-025 remaining SHALL be an unsigned CNT_W counter and SHALL never wrap below 0.

Reset
REQ-026 rst=1 SHALL force IDLE, remaining=0, beat index=0, and every output to 0, including mid-RUN and mid-READOUT.
REQ-027 rst SHALL take priority over start on the same edge.

Configuration
REQ-028 With RUNUP_CTRL_WATCHDOG_EN defined, WD_CYCLES consecutive RUN cycles with src_valid=0 SHALL set err=1 and go to DONE with no readout (done pulses).
REQ-029 With RUNUP_CTRL_WATCHDOG_EN defined, err SHALL stay 1 until the next accepted start or rst; any src_valid=1 SHALL reset the stall count.
REQ-030 Without RUNUP_CTRL_WATCHDOG_EN, RUN SHALL wait indefinitely, err SHALL be tied to 0, and no watchdog logic SHALL be instantiated.

Structure
REQ-031 Package runup_pkg SHALL hold the state enum type, NUM_BINS and CNT_W defaults, and the beat index width.
REQ-032 The stall counter SHALL be sub-module runup_wdog (inputs: clear, tick; output: expired), instantiated only under RUNUP_CTRL_WATCHDOG_EN.

Verification
REQ-033 SHALL test: start with num_words=3 and src_valid held 1 -> dp_clr 1 cycle, then exactly 3 dp_adv cycles, 1 SETTLE cycle, 33 beats with res_last on beat 32, done pulse.
REQ-034 SHALL test: num_words=5 with src_valid toggling 1,0,1,0,... -> dp_adv count=5 and never asserted while src_valid=0.
REQ-035 SHALL test: random res_ready during READOUT -> res_data stable across stalls and beat order total, bin0..bin31.
REQ-036 SHALL test: rst=1 during READOUT beat 10 -> next cycle IDLE with all outputs 0; a new start succeeds.
REQ-037 SHALL test, with macro and WD_CYCLES=16: src_valid held 0 in RUN -> err=1 after 16 cycles, done pulse, res_valid never 1.
REQ-038 SHALL test: num_words=0 -> no dp_adv, 33 beats of zeros, plus start pulsed during busy ignored.
